of_ex: RTL
==========

# of_ex

Pipeline register between the dual-issue operand-fetch (of) stage and the execute (ex) stage. Each cycle it captures both instruction slots' resolved operands, HI/LO values, control fields and exception vectors from of, and presents them registered to ex. It implements the hold, bubble-insert and flush rules that let of raise a load-use stall while older instructions keep draining, and it forces slot 2 to a bubble whenever of issues only one instruction.

## Interface
Parameters: none; widths come from the shared defines (InstAddrBus 32, RegBus 32, AluOpBus 8, AluSelBus 3, RegAddrBus 5).
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high (RstEnable)
- flush  in  1  exception/ERET flush from commit; kills the captured pair
- of_stall  in  1  of stage held (load-use stall or upstream stall)
- ex_stall  in  1  ex stage held (multi-cycle div/mult, mem stall)
- inst1_addr_i, inst2_addr_i  in  32  slot PCs
- aluop1_i, aluop2_i  in  8; alusel1_i, alusel2_i  in  3
- waddr1_i, waddr2_i  in  5; we1_i, we2_i  in  1
- reg1_i..reg4_i  in  32  resolved operands (reg1/2 slot 1, reg3/4 slot 2)
- hi_i, lo_i  in  32  forwarded HI/LO
- is_in_delayslot1_i, is_in_delayslot2_i  in  1
- imm_fnl1_i  in  32; cp0_addr_i  in  5; cp0_sel_i  in  3
- issue_i  in  1  1 = both slots valid
- exception_type1_i, exception_type2_i  in  32
- ex_* outputs  out  same widths  registered copy of every input above, e.g. ex_aluop1_o, ex_reg3_o, ex_issue_o, ex_exception_type2_o

## Operation
- Bubble value per slot: aluop EXE_NOP_OP, alusel EXE_RES_NOP, we WriteDisable, waddr 0, operands 0, inst_addr 0, delayslot 0, exception_type 0. Bubble also clears hi/lo, imm, cp0 fields and ex_issue_o to 0.
- Priority per rising edge:
  1. rst: both slots become bubbles.
  2. flush: both slots become bubbles, regardless of the stall inputs.
  3. ex_stall: hold all outputs unchanged, regardless of of_stall.
  4. of_stall and not ex_stall: load bubbles into both slots, because the older ex contents move on and of must not be duplicated.
  5. Otherwise capture. Slot 1 is captured as given. If issue_i=0, slot 2 is captured as a bubble, ex_issue_o=0, and slot-1 fields, hi/lo and cp0 are still captured.
- ex_stall with flush: flush wins. The exception is already committed, so held contents are discarded.
- No arithmetic is performed; data passes through bit-exact.
- Structurally this is a two-state controller per edge, VALID/BUBBLE. Only the ex_issue_o and we flags encode the state; no separate state register.

## Timing
- Latency: 1 cycle, input at edge N appears at outputs after edge N.
- All outputs equal bubble values from the first edge with rst=1 until the first capture edge after rst deasserts.
- Hold lasts as many cycles as ex_stall is high; outputs are stable throughout.
- A single of_stall cycle produces exactly one bubble cycle at ex. An of_stall lasting k cycles produces k bubbles.
- Flush takes effect on the same edge it is sampled; the next cycle shows a bubble. The first post-flush capture happens on the following edge.
- Outputs are purely registered, with no combinational path from input to output.

## Structure
- The bubble constants (EXE_NOP_OP, EXE_RES_NOP, ZeroWord, WriteDisable, Stop/NoStop) and the bus widths already live in defines.v. No new constants are added.
- A per-slot sub-module, of_ex_slot, is natural. It holds addr, aluop, alusel, waddr, we, two operands, delayslot and exception_type, with capture, bubble and hold controls. Instantiate it twice, and feed slot 2's bubble term with ~issue_i.
- Shared fields (hi/lo, imm, cp0, issue) stay in the top level.

## Test plan
- Reset: rst=1 for 2 cycles with arbitrary inputs -> ex_we1_o=ex_we2_o=0, ex_aluop1_o=EXE_NOP_OP, ex_reg1_o=0, ex_issue_o=0.
- Dual capture: issue_i=1, reg1_i=32'h1234_5678, waddr2_i=5'd9, we2_i=1 -> next cycle ex_reg1_o=32'h1234_5678, ex_waddr2_o=9, ex_we2_o=1, ex_issue_o=1.
- Single issue: issue_i=0, we2_i=1, exception_type2_i=32'h100 -> ex_we2_o=0, ex_exception_type2_o=0, and slot 1 is captured normally.
- Load-use bubble: one cycle with of_stall=1 and ex_stall=0 -> exactly one cycle of ex_we1_o=0 and ex_aluop1_o=EXE_NOP_OP; when of_stall drops, the same pair is captured.
- Hold: ex_stall=1 for 3 cycles while inputs change -> outputs frozen at their pre-stall values, e.g. ex_reg3_o=32'hCAFE_0000 throughout.
- Flush during hold: ex_stall=1 and flush=1 in the same cycle -> next cycle all outputs are bubbles; flush overrides the stall.

Source files
------------

// File: rtl/of_ex_pkg.sv
// Shared widths, bubble constants and the per-slot record used by the of->ex pipeline register.
package of_ex_pkg;

    localparam int InstAddrBus = 32;
    localparam int RegBus      = 32;
    localparam int AluOpBus    = 8;
    localparam int AluSelBus   = 3;
    localparam int RegAddrBus  = 5;

    localparam logic                 RstEnable    = 1'b1;
    localparam logic                 Stop         = 1'b1;
    localparam logic                 NoStop       = 1'b0;
    localparam logic                 WriteEnable  = 1'b1;
    localparam logic                 WriteDisable = 1'b0;
    localparam logic [RegBus-1:0]    ZeroWord     = 32'h0000_0000;
    localparam logic [AluOpBus-1:0]  EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [AluSelBus-1:0] EXE_RES_NOP  = 3'b000;

    typedef struct packed {
        logic [InstAddrBus-1:0] inst_addr;
        logic [AluOpBus-1:0]    aluop;
        logic [AluSelBus-1:0]   alusel;
        logic [RegAddrBus-1:0]  waddr;
        logic                   we;
        logic [RegBus-1:0]      op_a;
        logic [RegBus-1:0]      op_b;
        logic                   in_delayslot;
        logic [RegBus-1:0]      exception_type;
    } slot_t;

    // A bubble slot is a no-op that writes nothing and carries no exception.
    function automatic slot_t bubble_slot();
        slot_t s;
        s.inst_addr      = ZeroWord;
        s.aluop          = EXE_NOP_OP;
        s.alusel         = EXE_RES_NOP;
        s.waddr          = '0;
        s.we             = WriteDisable;
        s.op_a           = ZeroWord;
        s.op_b           = ZeroWord;
        s.in_delayslot   = 1'b0;
        s.exception_type = ZeroWord;
        return s;
    endfunction

endpackage

// File: rtl/of_ex_slot.sv
// One instruction slot of the of->ex register with kill, hold and bubble-insert controls.
module of_ex_slot
    import of_ex_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  kill,
    input  logic  hold,
    input  logic  bubble,
    input  slot_t slot_i,
    output slot_t slot_o
);

    // Kill beats hold so a flush discards contents ex is still stalled on.
    always_ff @(posedge clk) begin
        if (rst == RstEnable || kill) begin
            slot_o <= bubble_slot();
        end else if (hold != Stop) begin
            if (bubble) begin
                slot_o <= bubble_slot();
            end else begin
                slot_o <= slot_i;
            end
        end
    end

endmodule

// File: rtl/of_ex.sv
// Dual-issue of->ex pipeline register: two slot registers plus shared HI/LO, immediate, CP0 and issue fields.
module of_ex
    import of_ex_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   of_stall,
    input  logic                   ex_stall,
    input  logic [InstAddrBus-1:0] inst1_addr_i,
    input  logic [InstAddrBus-1:0] inst2_addr_i,
    input  logic [AluOpBus-1:0]    aluop1_i,
    input  logic [AluOpBus-1:0]    aluop2_i,
    input  logic [AluSelBus-1:0]   alusel1_i,
    input  logic [AluSelBus-1:0]   alusel2_i,
    input  logic [RegAddrBus-1:0]  waddr1_i,
    input  logic [RegAddrBus-1:0]  waddr2_i,
    input  logic                   we1_i,
    input  logic                   we2_i,
    input  logic [RegBus-1:0]      reg1_i,
    input  logic [RegBus-1:0]      reg2_i,
    input  logic [RegBus-1:0]      reg3_i,
    input  logic [RegBus-1:0]      reg4_i,
    input  logic [RegBus-1:0]      hi_i,
    input  logic [RegBus-1:0]      lo_i,
    input  logic                   is_in_delayslot1_i,
    input  logic                   is_in_delayslot2_i,
    input  logic [RegBus-1:0]      imm_fnl1_i,
    input  logic [4:0]             cp0_addr_i,
    input  logic [2:0]             cp0_sel_i,
    input  logic                   issue_i,
    input  logic [RegBus-1:0]      exception_type1_i,
    input  logic [RegBus-1:0]      exception_type2_i,
    output logic [InstAddrBus-1:0] ex_inst1_addr_o,
    output logic [InstAddrBus-1:0] ex_inst2_addr_o,
    output logic [AluOpBus-1:0]    ex_aluop1_o,
    output logic [AluOpBus-1:0]    ex_aluop2_o,
    output logic [AluSelBus-1:0]   ex_alusel1_o,
    output logic [AluSelBus-1:0]   ex_alusel2_o,
    output logic [RegAddrBus-1:0]  ex_waddr1_o,
    output logic [RegAddrBus-1:0]  ex_waddr2_o,
    output logic                   ex_we1_o,
    output logic                   ex_we2_o,
    output logic [RegBus-1:0]      ex_reg1_o,
    output logic [RegBus-1:0]      ex_reg2_o,
    output logic [RegBus-1:0]      ex_reg3_o,
    output logic [RegBus-1:0]      ex_reg4_o,
    output logic [RegBus-1:0]      ex_hi_o,
    output logic [RegBus-1:0]      ex_lo_o,
    output logic                   ex_is_in_delayslot1_o,
    output logic                   ex_is_in_delayslot2_o,
    output logic [RegBus-1:0]      ex_imm_fnl1_o,
    output logic [4:0]             ex_cp0_addr_o,
    output logic [2:0]             ex_cp0_sel_o,
    output logic                   ex_issue_o,
    output logic [RegBus-1:0]      ex_exception_type1_o,
    output logic [RegBus-1:0]      ex_exception_type2_o
);

    slot_t slot1_in;
    slot_t slot2_in;
    slot_t slot1_q;
    slot_t slot2_q;

    assign slot1_in = '{inst_addr: inst1_addr_i, aluop: aluop1_i, alusel: alusel1_i,
                        waddr: waddr1_i, we: we1_i, op_a: reg1_i, op_b: reg2_i,
                        in_delayslot: is_in_delayslot1_i, exception_type: exception_type1_i};
    assign slot2_in = '{inst_addr: inst2_addr_i, aluop: aluop2_i, alusel: alusel2_i,
                        waddr: waddr2_i, we: we2_i, op_a: reg3_i, op_b: reg4_i,
                        in_delayslot: is_in_delayslot2_i, exception_type: exception_type2_i};

    of_ex_slot u_slot1 (
        .clk    (clk),
        .rst    (rst),
        .kill   (flush),
        .hold   (ex_stall),
        .bubble (of_stall),
        .slot_i (slot1_in),
        .slot_o (slot1_q)
    );

    // Slot 2 also turns into a bubble when of only issued slot 1.
    of_ex_slot u_slot2 (
        .clk    (clk),
        .rst    (rst),
        .kill   (flush),
        .hold   (ex_stall),
        .bubble (of_stall | ~issue_i),
        .slot_i (slot2_in),
        .slot_o (slot2_q)
    );

    // Shared fields follow slot 1's rules; issue itself records whether slot 2 is live.
    always_ff @(posedge clk) begin
        if (rst == RstEnable || flush) begin
            ex_hi_o       <= ZeroWord;
            ex_lo_o       <= ZeroWord;
            ex_imm_fnl1_o <= ZeroWord;
            ex_cp0_addr_o <= '0;
            ex_cp0_sel_o  <= '0;
            ex_issue_o    <= 1'b0;
        end else if (ex_stall != Stop) begin
            if (of_stall == Stop) begin
                ex_hi_o       <= ZeroWord;
                ex_lo_o       <= ZeroWord;
                ex_imm_fnl1_o <= ZeroWord;
                ex_cp0_addr_o <= '0;
                ex_cp0_sel_o  <= '0;
                ex_issue_o    <= 1'b0;
            end else begin
                ex_hi_o       <= hi_i;
                ex_lo_o       <= lo_i;
                ex_imm_fnl1_o <= imm_fnl1_i;
                ex_cp0_addr_o <= cp0_addr_i;
                ex_cp0_sel_o  <= cp0_sel_i;
                ex_issue_o    <= issue_i;
            end
        end
    end

    assign ex_inst1_addr_o       = slot1_q.inst_addr;
    assign ex_aluop1_o           = slot1_q.aluop;
    assign ex_alusel1_o          = slot1_q.alusel;
    assign ex_waddr1_o           = slot1_q.waddr;
    assign ex_we1_o              = slot1_q.we;
    assign ex_reg1_o             = slot1_q.op_a;
    assign ex_reg2_o             = slot1_q.op_b;
    assign ex_is_in_delayslot1_o = slot1_q.in_delayslot;
    assign ex_exception_type1_o  = slot1_q.exception_type;

    assign ex_inst2_addr_o       = slot2_q.inst_addr;
    assign ex_aluop2_o           = slot2_q.aluop;
    assign ex_alusel2_o          = slot2_q.alusel;
    assign ex_waddr2_o           = slot2_q.waddr;
    assign ex_we2_o              = slot2_q.we;
    assign ex_reg3_o             = slot2_q.op_a;
    assign ex_reg4_o             = slot2_q.op_b;
    assign ex_is_in_delayslot2_o = slot2_q.in_delayslot;
    assign ex_exception_type2_o  = slot2_q.exception_type;

endmodule
